branch_resolve: RTL and testbench

- EX-stage counterpart of the IF-stage 2-bit branch predictor.
- Buffers each prediction IF issues for a B/BL instruction, pops the matching record when EX resolves the branch, and compares predicted against actual outcome.
- Drives the predictor's history-update port (we/in_b) and, on mispredict, a multi-cycle pipeline flush with the corrected PC.
- Keeps branch and mispredict statistics counters.

---
 rtl/branch_resolve_pkg.sv | 17 +
 rtl/branch_resolve_pred_fifo.sv | 68 ++++++
 rtl/branch_resolve.sv | 144 ++++++++++++++
 tb/tb_branch_resolve.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_pkg.sv
// Shared types for the EX-stage branch resolution unit: record layout and FSM states.
package branch_resolve_pkg;

  localparam int PC_W = 32;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } br_state_e;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            taken;
    logic [PC_W-1:0] target;
  } pred_rec_t;

endpackage

// File: rtl/branch_resolve_pred_fifo.sv
// In-flight prediction record FIFO; extra pointer MSB distinguishes full from empty.
module branch_resolve_pred_fifo
  import branch_resolve_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      resetn,
  input  logic      clr_i,
  input  logic      push_i,
  input  pred_rec_t wdata_i,
  input  logic      pop_i,
  output pred_rec_t rdata_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  pred_rec_t     mem_q [DEPTH];

  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign rdata_o = mem_q[rd_q[AW-1:0]];

  // Pointer next-state; clear wins over any same-cycle push or pop.
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (clr_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push_i) begin
        wr_d = wr_q + PW'(1);
      end else begin
        wr_d = wr_q;
      end
      if (pop_i) begin
        rd_d = rd_q + PW'(1);
      end else begin
        rd_d = rd_q;
      end
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Record storage.
  always_ff @(posedge clk) begin
    if (push_i && !clr_i) begin
      mem_q[wr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/branch_resolve.sv
// Resolves IF-stage predictions in EX: history update, mispredict flush/redirect, statistics.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            pred_valid,
  input  logic [PC_W-1:0] pred_pc,
  input  logic            pred_taken,
  input  logic [PC_W-1:0] pred_target,
  output logic            pred_ready,
  input  logic            res_valid,
  input  logic            res_taken,
  input  logic [PC_W-1:0] res_target,
  output logic            res_ready,
  output logic            upd_we,
  output logic            upd_taken,
  output logic            flush,
  output logic [PC_W-1:0] redirect_pc,
  output logic [31:0]     cnt_branch,
  output logic [31:0]     cnt_mispred
);

  localparam int FCNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  br_state_e       state_q, state_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic [PC_W-1:0] redirect_q, redirect_d;
  logic            upd_we_q, upd_taken_q, upd_taken_d;
  logic [31:0]     cnt_branch_q, cnt_branch_d;
  logic [31:0]     cnt_mispred_q, cnt_mispred_d;

  pred_rec_t       wr_rec_s, rd_rec_s;
  logic            fifo_full_s, fifo_empty_s, fifo_clr_s;
  logic            push_s, pop_s, mispredict_s, mis_pop_s;

  assign pred_ready = (state_q == ST_IDLE) && !fifo_full_s;
  assign res_ready  = (state_q == ST_IDLE) && !fifo_empty_s;
  assign push_s     = pred_valid && pred_ready;
  assign pop_s      = res_valid && res_ready;

  assign wr_rec_s = '{pc: pred_pc, taken: pred_taken, target: pred_target};

  branch_resolve_pred_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .clr_i   (fifo_clr_s),
    .push_i  (push_s),
    .wdata_i (wr_rec_s),
    .pop_i   (pop_s),
    .rdata_o (rd_rec_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  // A taken/taken pair still mispredicts when the predicted target was stale.
  assign mispredict_s = (rd_rec_s.taken != res_taken) ||
                        (rd_rec_s.taken && res_taken && (rd_rec_s.target != res_target));
  assign mis_pop_s    = pop_s && mispredict_s;

  // FSM next-state, flush down-counter, redirect capture and FIFO clear.
  always_comb begin
    state_d    = state_q;
    fcnt_d     = fcnt_q;
    redirect_d = redirect_q;
    fifo_clr_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mis_pop_s) begin
          state_d    = ST_FLUSH;
          fcnt_d     = FCNT_W'(FLUSH_CYCLES - 1);
          redirect_d = res_taken ? res_target : (rd_rec_s.pc + 32'd4);
          fifo_clr_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (fcnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          fcnt_d = fcnt_q - FCNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Saturating statistics and predictor update value.
  always_comb begin
    cnt_branch_d  = cnt_branch_q;
    cnt_mispred_d = cnt_mispred_q;
    upd_taken_d   = upd_taken_q;
    if (pop_s) begin
      upd_taken_d = res_taken;
      if (cnt_branch_q != 32'hFFFF_FFFF) begin
        cnt_branch_d = cnt_branch_q + 32'd1;
      end else begin
        cnt_branch_d = cnt_branch_q;
      end
      if (mispredict_s && (cnt_mispred_q != 32'hFFFF_FFFF)) begin
        cnt_mispred_d = cnt_mispred_q + 32'd1;
      end else begin
        cnt_mispred_d = cnt_mispred_q;
      end
    end else begin
      upd_taken_d = upd_taken_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      fcnt_q        <= '0;
      redirect_q    <= '0;
      upd_we_q      <= 1'b0;
      upd_taken_q   <= 1'b0;
      cnt_branch_q  <= 32'd0;
      cnt_mispred_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      fcnt_q        <= fcnt_d;
      redirect_q    <= redirect_d;
      upd_we_q      <= pop_s;
      upd_taken_q   <= upd_taken_d;
      cnt_branch_q  <= cnt_branch_d;
      cnt_mispred_q <= cnt_mispred_d;
    end
  end

  assign flush       = (state_q == ST_FLUSH);
  assign redirect_pc = redirect_q;
  assign upd_we      = upd_we_q;
  assign upd_taken   = upd_taken_q;
  assign cnt_branch  = cnt_branch_q;
  assign cnt_mispred = cnt_mispred_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed scenarios plus random traffic vs a queue model.
module tb_branch_resolve;

  localparam int DEPTH = 4;
  localparam int FC    = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        pred_valid, pred_taken, res_valid, res_taken;
  logic [31:0] pred_pc, pred_target, res_target;
  logic        pred_ready, res_ready, upd_we, upd_taken, flush;
  logic [31:0] redirect_pc, cnt_branch, cnt_mispred;

  always #5 clk = ~clk;

  branch_resolve #(.DEPTH(DEPTH), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .resetn(resetn),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .pred_target(pred_target), .pred_ready(pred_ready),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .res_ready(res_ready), .upd_we(upd_we), .upd_taken(upd_taken),
    .flush(flush), .redirect_pc(redirect_pc),
    .cnt_branch(cnt_branch), .cnt_mispred(cnt_mispred)
  );

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } tb_rec_t;

  tb_rec_t     mq[$];
  int          flush_left;
  logic        exp_upd_we, exp_upd_taken;
  logic [31:0] exp_redirect, exp_cb, exp_cm;
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic logic exp_pred_ready();
    return (flush_left == 0) && (mq.size() < DEPTH);
  endfunction

  function automatic logic exp_res_ready();
    return (flush_left == 0) && (mq.size() > 0);
  endfunction

  task automatic model_reset();
    mq.delete();
    flush_left    = 0;
    exp_upd_we    = 1'b0;
    exp_upd_taken = 1'b0;
    exp_redirect  = 32'd0;
    exp_cb        = 32'd0;
    exp_cm        = 32'd0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    pred_valid = 1'b0; pred_pc = 32'd0; pred_taken = 1'b0; pred_target = 32'd0;
    res_valid = 1'b0; res_taken = 1'b0; res_target = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  // One clock of stimulus; updates the model from the behavioural rules, samples #1 after the edge.
  task automatic drive_cycle(input logic pv, input logic [31:0] ppc, input logic pt,
                             input logic [31:0] ptg, input logic rv, input logic rt,
                             input logic [31:0] rtg);
    logic    acc, popd, mis;
    tb_rec_t r, w;
    pred_valid = pv; pred_pc = ppc; pred_taken = pt; pred_target = ptg;
    res_valid = rv; res_taken = rt; res_target = rtg;
    acc  = pv && exp_pred_ready();
    popd = rv && exp_res_ready();
    mis  = 1'b0;
    r    = '{pc: 32'd0, taken: 1'b0, target: 32'd0};
    if (popd) begin
      r   = mq.pop_front();
      mis = (r.taken != rt) || (r.taken && rt && (r.target != rtg));
      exp_upd_taken = rt;
      if (exp_cb != 32'hFFFF_FFFF) exp_cb = exp_cb + 32'd1;
      if (mis && exp_cm != 32'hFFFF_FFFF) exp_cm = exp_cm + 32'd1;
    end
    exp_upd_we = popd;
    if (flush_left > 0) flush_left--;
    if (mis) begin
      flush_left   = FC;
      mq.delete();
      exp_redirect = rt ? rtg : r.pc + 32'd4;
    end else if (acc) begin
      w = '{pc: ppc, taken: pt, target: ptg};
      mq.push_back(w);
    end
    @(posedge clk);
    #1;
    pred_valid = 1'b0;
    res_valid  = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (pred_ready !== 1'b1) begin n_fail++; $display("FAIL reset_pred_ready got %b want 1", pred_ready); end
    n_tests++; if (res_ready !== 1'b0) begin n_fail++; $display("FAIL reset_res_ready got %b want 0", res_ready); end
    n_tests++; if ({upd_we, upd_taken, flush} !== 3'b000) begin n_fail++; $display("FAIL reset_strobes got %b want 000", {upd_we, upd_taken, flush}); end
    n_tests++; if ({redirect_pc, cnt_branch, cnt_mispred} !== 96'd0) begin n_fail++; $display("FAIL reset_regs got %h/%h/%h want 0", redirect_pc, cnt_branch, cnt_mispred); end
  endtask

  task automatic test_correct();
    drive_cycle(1'b1, 32'h1c00_0000, 1'b1, 32'h1c00_0040, 1'b0, 1'b0, 32'd0);
    n_tests++; if (res_ready !== 1'b1) begin n_fail++; $display("FAIL correct_res_ready got %b want 1", res_ready); end
    drive_cycle(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h1c00_0040);
    n_tests++; if ({upd_we, upd_taken, flush} !== 3'b110) begin n_fail++; $display("FAIL correct_upd got %b want 110", {upd_we, upd_taken, flush}); end
    n_tests++; if (cnt_branch !== exp_cb || cnt_mispred !== exp_cm) begin n_fail++; $display("FAIL correct_cnt got %0d/%0d want %0d/%0d", cnt_branch, cnt_mispred, exp_cb, exp_cm); end
    drive_cycle(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    n_tests++; if (upd_we !== 1'b0) begin n_fail++; $display("FAIL correct_upd_pulse got %b want 0", upd_we); end
  endtask

  task automatic test_mispredict_dir();
    int nfl;
    drive_cycle(1'b1, 32'h0000_2000, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'd0);
    drive_cycle(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    n_tests++; if (redirect_pc !== 32'h0000_2004) begin n_fail++; $display("FAIL dir_redirect got %h want 00002004", redirect_pc); end
    n_tests++; if ({upd_we, upd_taken} !== 2'b10) begin n_fail++; $display("FAIL dir_upd got %b want 10", {upd_we, upd_taken}); end
    n_tests++; if (cnt_mispred !== exp_cm) begin n_fail++; $display("FAIL dir_cnt_mispred got %0d want %0d", cnt_mispred, exp_cm); end
    nfl = 0;
    for (int i = 0; i < 6; i++) begin
      if (flush === 1'b1) nfl++;
      drive_cycle(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    end
    n_tests++; if (nfl != FC) begin n_fail++; $display("FAIL dir_flush_len got %0d want %0d", nfl, FC); end
    n_tests++; if (res_ready !== 1'b0 || pred_ready !== 1'b1) begin n_fail++; $display("FAIL dir_empty_after got %b%b want 10", pred_ready, res_ready); end
  endtask

  task automatic test_mispredict_target();
    drive_cycle(1'b1, 32'h0000_3000, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'd0);
    drive_cycle(1'b1, 32'h0000_3010, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0200);
    n_tests++; if (flush !== 1'b1 || redirect_pc !== 32'h0000_0200) begin n_fail++; $display("FAIL tgt_flush got %b/%h want 1/00000200", flush, redirect_pc); end
    n_tests++; if (pred_ready !== 1'b0 || res_ready !== 1'b0) begin n_fail++; $display("FAIL tgt_ready_in_flush got %b%b want 00", pred_ready, res_ready); end
    repeat (FC) drive_cycle(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    n_tests++; if (flush !== 1'b0 || res_ready !== 1'b0) begin n_fail++; $display("FAIL tgt_discard got flush=%b res_ready=%b want 0/0", flush, res_ready); end
  endtask

  task automatic test_full();
    logic fr;
    for (int i = 0; i < DEPTH; i++)
      drive_cycle(1'b1, 32'h0000_4000 + 32'(i * 16), i[0], 32'h0000_5000 + 32'(i * 64), 1'b0, 1'b0, 32'd0);
    n_tests++; if (pred_ready !== 1'b0) begin n_fail++; $display("FAIL full_pred_ready got %b want 0", pred_ready); end
    drive_cycle(1'b1, 32'h0000_7777, 1'b1, 32'h0000_8888, 1'b0, 1'b0, 32'd0);
    n_tests++; if (pred_ready !== 1'b0 || res_ready !== 1'b1) begin n_fail++; $display("FAIL full_5th got %b%b want 01", pred_ready, res_ready); end
    for (int i = 0; i < DEPTH; i++) begin
      fr = (i == 0);
      drive_cycle(fr, 32'h0000_9999, 1'b0, 32'd0, 1'b1, mq[0].taken, mq[0].target);
      n_tests++; if (flush !== 1'b0 || pred_ready !== 1'b1 || upd_taken !== exp_upd_taken) begin
        n_fail++; $display("FAIL full_pop%0d got flush=%b pred_ready=%b upd_taken=%b want 0/1/%b", i, flush, pred_ready, upd_taken, exp_upd_taken);
      end
    end
    n_tests++; if (res_ready !== 1'b0 || cnt_branch !== exp_cb || cnt_mispred !== exp_cm) begin
      n_fail++; $display("FAIL full_drain got res_ready=%b cnt=%0d/%0d want 0 %0d/%0d", res_ready, cnt_branch, cnt_mispred, exp_cb, exp_cm);
    end
  endtask

  task automatic test_random();
    logic        pv, pt, rv, rt;
    logic [31:0] ptg, rtg;
    for (int c = 0; c < 400; c++) begin
      n_tests++; if (pred_ready !== exp_pred_ready() || res_ready !== exp_res_ready()) begin
        n_fail++; $display("FAIL rnd_ready c=%0d got %b%b want %b%b", c, pred_ready, res_ready, exp_pred_ready(), exp_res_ready());
      end
      pv  = ($urandom_range(0, 2) != 0);
      pt  = $urandom_range(0, 1) == 1;
      ptg = ($urandom_range(0, 1) == 1) ? 32'h0000_0100 : 32'h0000_0200;
      rv  = ($urandom_range(0, 1) == 1);
      rt  = $urandom_range(0, 1) == 1;
      rtg = ($urandom_range(0, 1) == 1) ? 32'h0000_0100 : 32'h0000_0200;
      if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
        rt  = mq[0].taken;
        rtg = mq[0].target;
      end
      drive_cycle(pv, $urandom(), pt, ptg, rv, rt, rtg);
      n_tests++; if (upd_we !== exp_upd_we || upd_taken !== exp_upd_taken || flush !== (flush_left > 0)) begin
        n_fail++; $display("FAIL rnd_out c=%0d got we=%b tk=%b fl=%b want %b %b %b", c, upd_we, upd_taken, flush, exp_upd_we, exp_upd_taken, flush_left > 0);
      end
      n_tests++; if (cnt_branch !== exp_cb || cnt_mispred !== exp_cm) begin
        n_fail++; $display("FAIL rnd_cnt c=%0d got %0d/%0d want %0d/%0d", c, cnt_branch, cnt_mispred, exp_cb, exp_cm);
      end
      if (flush_left > 0) begin
        n_tests++; if (redirect_pc !== exp_redirect) begin n_fail++; $display("FAIL rnd_redirect c=%0d got %h want %h", c, redirect_pc, exp_redirect); end
      end
    end
  endtask

  task automatic test_saturation();
    repeat (FC + 1) drive_cycle(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    force dut.cnt_branch_q  = 32'hFFFF_FFFE;
    force dut.cnt_mispred_q = 32'hFFFF_FFFE;
    #1;
    release dut.cnt_branch_q;
    release dut.cnt_mispred_q;
    exp_cb = 32'hFFFF_FFFE;
    exp_cm = 32'hFFFF_FFFE;
    for (int k = 0; k < 2; k++) begin
      if (mq.size() == DEPTH) drive_cycle(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, mq[0].taken, mq[0].target);
      drive_cycle(1'b1, 32'h0000_6000, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
      while (mq.size() > 1) drive_cycle(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, mq[0].taken, mq[0].target);
      drive_cycle(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, ~mq[0].taken, 32'h0000_0300);
      n_tests++; if (cnt_branch !== exp_cb || cnt_mispred !== 32'hFFFF_FFFF) begin
        n_fail++; $display("FAIL sat%0d got %h/%h want %h/ffffffff", k, cnt_branch, cnt_mispred, exp_cb);
      end
      repeat (FC) drive_cycle(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    end
  endtask

  task automatic test_reset_mid_flush();
    drive_cycle(1'b1, 32'h0000_a000, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'd0);
    drive_cycle(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    drive_cycle(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    n_tests++; if (flush !== 1'b1) begin n_fail++; $display("FAIL midrst_pre got flush=%b want 1", flush); end
    resetn = 1'b0;
    #1;
    n_tests++; if (flush !== 1'b0) begin n_fail++; $display("FAIL midrst_async got flush=%b want 0", flush); end
    @(negedge clk);
    resetn = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    n_tests++; if (pred_ready !== 1'b1 || res_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready got %b%b want 10", pred_ready, res_ready); end
    n_tests++; if (cnt_branch !== 32'd0 || cnt_mispred !== 32'd0) begin n_fail++; $display("FAIL midrst_cnt got %0d/%0d want 0/0", cnt_branch, cnt_mispred); end
  endtask

  initial begin
    test_reset();
    test_correct();
    test_mispredict_dir();
    test_mispredict_target();
    test_full();
    test_random();
    test_saturation();
    test_reset_mid_flush();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
